// File: rtl/network_scheduler_if.sv
// Frame, network-drive and result signals between the frame source, network_scheduler and the network.
// Master is the scheduler side; slave is the frame source / result consumer side.
interface network_scheduler_if #(
  parameter int HEIGHT = 7,
  parameter int CNT_W  = 8
);
  logic [HEIGHT-1:0] frame_in;
  logic              frame_valid;
  logic              frame_ready;
  logic [HEIGHT-1:0] pixels;
  logic              net_rst_n;
  logic              neuron_out;
  logic [CNT_W-1:0]  result_count;
  logic              result_hit;
  logic              result_valid;
  logic              result_ready;
  logic              busy;

  modport master (
    input  frame_in, frame_valid, neuron_out, result_ready,
    output frame_ready, pixels, net_rst_n, result_count, result_hit, result_valid, busy
  );

  modport slave (
    output frame_in, frame_valid, neuron_out, result_ready,
    input  frame_ready, pixels, net_rst_n, result_count, result_hit, result_valid, busy
  );
endinterface

// File: rtl/network_scheduler.sv
// Frame sequencer for the spiking network: clear, present WINDOW cycles, count spikes (optional REST drain via NET_SCHED_REST_EN).
// Latency: frame handshake to result_valid is WINDOW+3 cycles (WINDOW+REST+3 with NET_SCHED_REST_EN).
// Backpressure: one frame in flight; frame_ready stays low until the result is taken with result_ready.
module network_scheduler #(
  parameter int HEIGHT = 7,
  parameter int WINDOW = 14336,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4,
  parameter int REST   = 64
) (
  input  logic                clk,
  input  logic                rst,
  network_scheduler_if.master bus
);

`ifdef NET_SCHED_REST_EN
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PRESENT, S_REST, S_REPORT} state_t;
  localparam logic [15:0] REST_LD = 16'(REST);
  logic [15:0] rest_cnt, rest_nxt;
`else
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PRESENT, S_REPORT} state_t;
  logic unused_rest;
  assign unused_rest = ^16'(REST);
`endif

  localparam logic [23:0]      WIN_LD  = 24'(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  state_t            state, state_nxt;
  logic [23:0]       timer, timer_nxt;
  logic [HEIGHT-1:0] frame_q, frame_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              neuron_prev;
  logic              spike;

  logic              frame_ready_q;
  logic [HEIGHT-1:0] pixels_q;
  logic              net_rst_n_q;
  logic [CNT_W-1:0]  result_count_q;
  logic              result_hit_q;
  logic              result_valid_q;
  logic              busy_q;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    frame_nxt = frame_q;
    cnt_nxt   = cnt;
`ifdef NET_SCHED_REST_EN
    rest_nxt  = rest_cnt;
`endif
    spike = bus.neuron_out & ~neuron_prev;
    case (state)
      S_IDLE: begin
        if (bus.frame_valid & frame_ready_q) begin
          frame_nxt = bus.frame_in;
          timer_nxt = 24'd2;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_nxt = '0;
        if (timer == 24'd1) begin
          timer_nxt = WIN_LD;
          state_nxt = S_PRESENT;
        end else begin
          timer_nxt = timer - 24'd1;
        end
      end
      S_PRESENT: begin
        // Saturate rather than wrap so a busy neuron never reads as quiet.
        if (spike && (cnt != CNT_MAX)) cnt_nxt = cnt + 1'b1;
        if (timer == 24'd1) begin
`ifdef NET_SCHED_REST_EN
          rest_nxt  = REST_LD;
          state_nxt = S_REST;
`else
          state_nxt = S_REPORT;
`endif
        end else begin
          timer_nxt = timer - 24'd1;
        end
      end
`ifdef NET_SCHED_REST_EN
      S_REST: begin
        if (rest_cnt == 16'd1) state_nxt = S_REPORT;
        else                   rest_nxt  = rest_cnt - 16'd1;
      end
`endif
      S_REPORT: begin
        if (bus.result_ready & result_valid_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Edge history runs in every state so the first PRESENT cycle compares against the last CLEAR cycle.
  always_ff @(posedge clk) neuron_prev <= bus.neuron_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      timer          <= '0;
      frame_q        <= '0;
      cnt            <= '0;
`ifdef NET_SCHED_REST_EN
      rest_cnt       <= '0;
`endif
      frame_ready_q  <= 1'b0;
      pixels_q       <= '0;
      net_rst_n_q    <= 1'b0;
      result_count_q <= '0;
      result_hit_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      frame_q        <= frame_nxt;
      cnt            <= cnt_nxt;
`ifdef NET_SCHED_REST_EN
      rest_cnt       <= rest_nxt;
`endif
      frame_ready_q  <= (state_nxt == S_IDLE);
      busy_q         <= (state_nxt != S_IDLE);
      net_rst_n_q    <= (state_nxt != S_CLEAR);
      pixels_q       <= ((state_nxt == S_CLEAR) || (state_nxt == S_PRESENT)) ? frame_nxt : '0;
      result_valid_q <= (state_nxt == S_REPORT);
      if ((state_nxt == S_REPORT) && (state != S_REPORT)) begin
        result_count_q <= cnt_nxt;
        result_hit_q   <= (cnt_nxt >= THR);
      end
    end
  end

  assign bus.frame_ready  = frame_ready_q;
  assign bus.pixels       = pixels_q;
  assign bus.net_rst_n    = net_rst_n_q;
  assign bus.result_count = result_count_q;
  assign bus.result_hit   = result_hit_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_network_scheduler.sv
// Scoreboard bench for network_scheduler: expected count/hit queued at frame launch, compared when the result is handed off.
module tb_network_scheduler;
  localparam int HEIGHT = 7;
  localparam int WINDOW = 20;
  localparam int CNT_W  = 4;
  localparam int THRESH = 3;
  localparam int REST   = 5;
  localparam int SAT_W  = 3;
`ifdef NET_SCHED_REST_EN
  localparam int REST_CYC = REST;
`else
  localparam int REST_CYC = 0;
`endif

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             hit;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  network_scheduler_if #(.HEIGHT(HEIGHT), .CNT_W(CNT_W)) bus ();
  network_scheduler_if #(.HEIGHT(HEIGHT), .CNT_W(SAT_W)) sbus ();

  network_scheduler #(.HEIGHT(HEIGHT), .WINDOW(WINDOW), .CNT_W(CNT_W), .THRESH(THRESH), .REST(REST))
    dut (.clk(clk), .rst(rst), .bus(bus.master));
  network_scheduler #(.HEIGHT(HEIGHT), .WINDOW(WINDOW), .CNT_W(SAT_W), .THRESH(THRESH), .REST(REST))
    dut_sat (.clk(clk), .rst(rst), .bus(sbus.master));

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];
  int sat_q[$];
  logic [REST-1:0] rest_pat = '0;

  function automatic int model_count(input logic [WINDOW-1:0] pat, input logic prev0, input int maxv);
    int c;
    logic prev;
    c = 0;
    prev = prev0;
    for (int i = 0; i < WINDOW; i++) begin
      if (pat[i] && !prev && (c < maxv)) c++;
      prev = pat[i];
    end
    return c;
  endfunction

  task automatic start_frame(input logic [HEIGHT-1:0] frm, input logic clr_lvl);
    int waited;
    waited = 0;
    bus.frame_in = frm;
    bus.frame_valid = 1'b1;
    bus.neuron_out = clr_lvl;
    while ((bus.frame_ready !== 1'b1) && (waited < 200)) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 200) begin
      failures++;
      $display("FAIL frame_accept_timeout frame_ready=%b required 1", bus.frame_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.frame_valid = 1'b0;
        bus.frame_in = ~frm;
      end
      checks++;
      if ((bus.net_rst_n !== 1'b0) || (bus.pixels !== frm) || (bus.frame_ready !== 1'b0) || (bus.busy !== 1'b1)) begin
        failures++;
        $display("FAIL clear_cycle%0d net_rst_n=%b pixels=%b frame_ready=%b busy=%b required 0 %b 0 1",
                 i, bus.net_rst_n, bus.pixels, bus.frame_ready, bus.busy, frm);
      end
    end
  endtask

  task automatic present(input logic [HEIGHT-1:0] frm, input logic [WINDOW-1:0] pat);
    for (int i = 0; i < WINDOW; i++) begin
      @(negedge clk);
      bus.neuron_out = pat[i];
      checks++;
      if ((bus.net_rst_n !== 1'b1) || (bus.pixels !== frm) || (bus.result_valid !== 1'b0) || (bus.busy !== 1'b1)) begin
        failures++;
        $display("FAIL present_cycle%0d net_rst_n=%b pixels=%b result_valid=%b busy=%b required 1 %b 0 1",
                 i, bus.net_rst_n, bus.pixels, bus.result_valid, bus.busy, frm);
      end
    end
    for (int i = 0; i < REST_CYC; i++) begin
      @(negedge clk);
      bus.neuron_out = rest_pat[i];
      checks++;
      if ((bus.net_rst_n !== 1'b1) || (bus.pixels !== '0) || (bus.result_valid !== 1'b0) || (bus.busy !== 1'b1)) begin
        failures++;
        $display("FAIL rest_cycle%0d net_rst_n=%b pixels=%b result_valid=%b busy=%b required 1 0 0 1",
                 i, bus.net_rst_n, bus.pixels, bus.result_valid, bus.busy);
      end
    end
    @(negedge clk);
    bus.neuron_out = 1'b0;
    checks++;
    if ((bus.result_valid !== 1'b1) || (bus.pixels !== '0) || (bus.frame_ready !== 1'b0)) begin
      failures++;
      $display("FAIL valid_rise result_valid=%b pixels=%b frame_ready=%b required 1 0 0",
               bus.result_valid, bus.pixels, bus.frame_ready);
    end
  endtask

  task automatic run_frame(input logic [HEIGHT-1:0] frm, input logic [WINDOW-1:0] pat, input logic clr_lvl);
    res_t e;
    int n;
    n = model_count(pat, clr_lvl, (1 << CNT_W) - 1);
    e.cnt = CNT_W'(n);
    e.hit = (n >= THRESH);
    exp_q.push_back(e);
    start_frame(frm, clr_lvl);
    present(frm, pat);
  endtask

  // Called on a valid cycle with result_ready already high: the handshake happens at the next edge.
  task automatic take_result();
    res_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty result_count=%0d required no result", bus.result_count);
    end else begin
      e = exp_q.pop_front();
      if ((bus.result_count !== e.cnt) || (bus.result_hit !== e.hit)) begin
        failures++;
        $display("FAIL result count=%0d hit=%b required count=%0d hit=%b",
                 bus.result_count, bus.result_hit, e.cnt, e.hit);
      end
    end
    @(negedge clk);
    checks++;
    if ((bus.result_valid !== 1'b0) || (bus.frame_ready !== 1'b1) || (bus.busy !== 1'b0)) begin
      failures++;
      $display("FAIL after_result result_valid=%b frame_ready=%b busy=%b required 0 1 0",
               bus.result_valid, bus.frame_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ((bus.net_rst_n !== 1'b0) || (bus.frame_ready !== 1'b0) || (bus.result_valid !== 1'b0) ||
          (bus.busy !== 1'b0) || (bus.pixels !== '0) || (bus.result_count !== '0) || (bus.result_hit !== 1'b0)) begin
        failures++;
        $display("FAIL reset_hold%0d net_rst_n=%b frame_ready=%b result_valid=%b busy=%b pixels=%b count=%0d hit=%b required all 0",
                 i, bus.net_rst_n, bus.frame_ready, bus.result_valid, bus.busy, bus.pixels, bus.result_count, bus.result_hit);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ((bus.frame_ready !== 1'b1) || (bus.net_rst_n !== 1'b1) || (bus.busy !== 1'b0)) begin
      failures++;
      $display("FAIL reset_release frame_ready=%b net_rst_n=%b busy=%b required 1 1 0",
               bus.frame_ready, bus.net_rst_n, bus.busy);
    end
  endtask

  task automatic test_basic();
    logic [WINDOW-1:0] pat;
    pat = '0;
    pat[2] = 1'b1; pat[6] = 1'b1; pat[10] = 1'b1; pat[15] = 1'b1;
    bus.result_ready = 1'b1;
    run_frame(7'b0101010, pat, 1'b0);
    take_result();
  endtask

  task automatic test_below_threshold();
    logic [WINDOW-1:0] pat;
    pat = '0;
    pat[0] = 1'b1;
    pat[WINDOW-1] = 1'b1;
    run_frame(7'b1000001, pat, 1'b0);
    take_result();
  endtask

  task automatic test_level_entry();
    logic [WINDOW-1:0] pat;
    pat = '0;
    for (int i = 0; i < 5; i++) pat[i] = 1'b1;
    pat[8] = 1'b1; pat[12] = 1'b1; pat[16] = 1'b1;
    run_frame(7'b0011100, pat, 1'b1);
    take_result();
  endtask

  task automatic test_backpressure();
    logic [WINDOW-1:0] pat;
    pat = '0;
    pat[1] = 1'b1; pat[5] = 1'b1; pat[9] = 1'b1;
    bus.result_ready = 1'b0;
    run_frame(7'b1110001, pat, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        bus.frame_in = 7'b0000111;
        bus.frame_valid = 1'b1;
      end
      checks++;
      if ((bus.result_valid !== 1'b1) || (bus.result_count !== exp_q[0].cnt) || (bus.result_hit !== exp_q[0].hit) ||
          (bus.frame_ready !== 1'b0) || (bus.pixels !== '0)) begin
        failures++;
        $display("FAIL hold_cycle%0d valid=%b count=%0d hit=%b frame_ready=%b pixels=%b required 1 %0d %b 0 0",
                 i, bus.result_valid, bus.result_count, bus.result_hit, bus.frame_ready, bus.pixels,
                 exp_q[0].cnt, exp_q[0].hit);
      end
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    take_result();
    pat = '0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[18] = 1'b1;
    run_frame(7'b0000111, pat, 1'b0);
    take_result();
  endtask

  task automatic test_saturation();
    logic [WINDOW-1:0] pat;
    int n;
    int waited;
    int e;
    for (int i = 0; i < WINDOW; i++) pat[i] = ((i % 2) == 0);
    n = model_count(pat, 1'b0, (1 << SAT_W) - 1);
    sat_q.push_back(n);
    sbus.frame_in = 7'b1111111;
    sbus.frame_valid = 1'b1;
    waited = 0;
    while ((sbus.frame_ready !== 1'b1) && (waited < 200)) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    sbus.frame_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < WINDOW; i++) begin
      @(negedge clk);
      sbus.neuron_out = pat[i];
    end
    for (int i = 0; i < REST_CYC; i++) begin
      @(negedge clk);
      sbus.neuron_out = 1'b0;
    end
    @(negedge clk);
    sbus.neuron_out = 1'b0;
    checks++;
    if (sbus.result_valid !== 1'b1) begin
      failures++;
      $display("FAIL sat_valid result_valid=%b required 1", sbus.result_valid);
    end
    e = sat_q.pop_front();
    checks++;
    if ((sbus.result_count !== SAT_W'(e)) || (sbus.result_hit !== (e >= THRESH))) begin
      failures++;
      $display("FAIL sat_result count=%0d hit=%b required count=%0d hit=%b",
               sbus.result_count, sbus.result_hit, e, (e >= THRESH));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [WINDOW-1:0] pat;
    logic seen;
    pat = '0;
    pat[0] = 1'b1; pat[3] = 1'b1; pat[6] = 1'b1;
    bus.result_ready = 1'b1;
    start_frame(7'b1100110, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.neuron_out = pat[i];
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.neuron_out = 1'b0;
    checks++;
    if ((bus.busy !== 1'b0) || (bus.result_valid !== 1'b0) || (bus.result_count !== '0) ||
        (bus.net_rst_n !== 1'b0) || (bus.frame_ready !== 1'b0) || (bus.pixels !== '0)) begin
      failures++;
      $display("FAIL mid_reset busy=%b valid=%b count=%0d net_rst_n=%b frame_ready=%b pixels=%b required all 0",
               bus.busy, bus.result_valid, bus.result_count, bus.net_rst_n, bus.frame_ready, bus.pixels);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || (bus.frame_ready !== 1'b1) || (bus.result_count !== '0)) begin
      failures++;
      $display("FAIL mid_reset_no_result seen_valid=%b frame_ready=%b count=%0d required 0 1 0",
               seen, bus.frame_ready, bus.result_count);
    end
    pat = '0;
    pat[11] = 1'b1;
    run_frame(7'b0011001, pat, 1'b0);
    take_result();
  endtask

`ifdef NET_SCHED_REST_EN
  task automatic test_rest();
    logic [WINDOW-1:0] pat;
    pat = '0;
    pat[5] = 1'b1;
    rest_pat = 5'b00101;
    run_frame(7'b1010101, pat, 1'b0);
    take_result();
    rest_pat = '0;
  endtask
`endif

  initial begin
    bus.frame_in = '0;
    bus.frame_valid = 1'b0;
    bus.neuron_out = 1'b0;
    bus.result_ready = 1'b0;
    sbus.frame_in = '0;
    sbus.frame_valid = 1'b0;
    sbus.neuron_out = 1'b0;
    sbus.result_ready = 1'b1;
    test_reset();
    test_basic();
    test_below_threshold();
    test_level_entry();
    test_backpressure();
    test_saturation();
    test_reset_mid();
`ifdef NET_SCHED_REST_EN
    test_rest();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/network_scheduler.md
# network_scheduler

Frame-level sequencer for the spiking `network` datapath. Accepts one binary pixel frame at a time over a valid/ready handshake, clears the network, presents the frame for a fixed window of `clk` cycles, and counts output spikes (rising edges of `neuron_out`). It then returns the spike count and a threshold decision over a second valid/ready handshake. It sits between the JTAG/host-side frame source and the `network` instance, driving that instance's `pixels` and `rst` inputs.

## Interface
- `HEIGHT`, 7, pixels per frame; must match the `network` instance.
- `WINDOW`, 14336, presentation length in `clk` cycles; legal range 1 to 2^24-1.
- `CNT_W`, 8, spike counter width.
- `THRESH`, 4, `result_hit` asserts when count >= `THRESH`; legal range 0 to 2^CNT_W-1.
- `REST`, 64, rest length in `clk` cycles, used only with `NET_SCHED_REST_EN`; legal range 1 to 2^16-1.

Ports:
- `clk` in 1: single clock, same domain as `network`.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `frame_in` in HEIGHT: pixel frame, sampled on handshake only.
- `frame_valid` in 1: frame offered.
- `frame_ready` out 1: scheduler can accept a frame.
- `pixels` out HEIGHT: to `network.pixels`.
- `net_rst_n` out 1: to `network.rst` (active low).
- `neuron_out` in 1: from `network.neuron_out`.
- `result_count` out CNT_W: spikes counted in the last window.
- `result_hit` out 1: `result_count >= THRESH`.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer takes result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, PRESENT, REST (macro only), REPORT.
- IDLE:
  - `frame_ready`=1, `pixels`=0, `net_rst_n`=1.
  - On `frame_valid & frame_ready`: latch `frame_in` into the frame register and go to CLEAR.
- CLEAR:
  - Exactly 2 cycles.
  - `net_rst_n`=0, `pixels`=latched frame.
  - Spike counter cleared to 0.
  - Then go to PRESENT.
- PRESENT:
  - Exactly `WINDOW` cycles.
  - `net_rst_n`=1, `pixels`=latched frame.
  - Counter increments on each cycle where `neuron_out & ~neuron_prev`.
- Edge detection:
  - `neuron_prev` is a register of `neuron_out`, updated every cycle in all states.
  - A level already high on entry to PRESENT therefore counts only if it was low in the last CLEAR cycle.
- Counter saturates at 2^CNT_W-1 and never wraps.
- After PRESENT, go to REST if the macro is enabled, otherwise go to REPORT.
- REPORT:
  - `result_valid`=1, `pixels`=0.
  - `result_count` and `result_hit` are stable while valid.
  - On `result_valid & result_ready`: go to IDLE.
- Frames offered outside IDLE are not accepted; `frame_ready`=0.
- `frame_in` changes after the handshake have no effect on the current frame.
- `rst` asserted in any state: next cycle the block is in IDLE with reset values. Any in-progress count is discarded and no result is produced.
- Reset values:
  - `frame_ready`=0, `pixels`=0, `net_rst_n`=0, `result_count`=0, `result_hit`=0, `result_valid`=0, `busy`=0.
  - `frame_ready`=1 and `net_rst_n`=1 from the first cycle after `rst` deasserts.

## Timing
- All outputs are registered; no combinational path from input to output.
- Frame handshake at edge t:
  - CLEAR occupies cycles t+1 and t+2.
  - PRESENT occupies t+3 through t+2+WINDOW.
  - `result_valid` rises at t+3+WINDOW, or at t+3+WINDOW+REST with the macro enabled.
- Result handshake at edge r: `result_valid`=0 and `frame_ready`=1 at r+1. The minimum frame-to-frame spacing is therefore WINDOW+4 cycles (WINDOW+REST+4 with the macro).
- `result_ready` held high before `result_valid`: the result is consumed on its first valid cycle, and valid is high for exactly one cycle.
- WINDOW counter width is 24 bits and REST counter width is 16 bits; both count down to 1 and then transition.

## Configuration
- `NET_SCHED_REST_EN` defined:
  - REST state compiled in.
  - For `REST` cycles after PRESENT: `pixels`=0, `net_rst_n`=1, and spikes are not counted.
  - This lets in-flight divider and delay pulses drain before the result is reported.
- Not defined:
  - REST state, REST counter and the `REST` parameter are unused.
  - PRESENT goes directly to REPORT.

## Test plan
(Bench: WINDOW=20, THRESH=3, CNT_W=4, REST=5.)
- Reset:
  - Hold `rst`=1 for 3 cycles, then release -> `net_rst_n`=0, `frame_ready`=0, `result_valid`=0 during reset.
  - `frame_ready`=1 and `net_rst_n`=1 on the first cycle after release.
- Basic frame:
  - Stimulus: frame 7'b0101010 accepted at t; model drives 4 spikes (1-cycle pulses) in PRESENT; `result_ready`=1.
  - `net_rst_n`=0 at t+1 and t+2; `pixels`=7'b0101010 from t+1 to t+22.
  - `result_valid` pulses at t+23 with count=4 and hit=1.
- Below threshold and saturation:
  - 2 spikes -> count=2, hit=0.
  - `neuron_out` toggling every cycle for 20 cycles (10 rising edges) with CNT_W=3 -> count=7 (saturated), hit=1.
- Backpressure and overlap:
  - `result_ready`=0 for 10 cycles -> result holds stable, `frame_ready`=0 throughout, a second `frame_valid` is ignored.
  - After `result_ready`=1 -> next frame accepted the cycle after the result handshake.
- Reset mid-PRESENT:
  - `rst` pulse at cycle 10 of PRESENT after 3 spikes -> no `result_valid`, `result_count`=0.
  - Next frame with 1 spike -> count=1.
- Macro on:
  - Spike during the REST window -> not counted.
  - `result_valid` rises at t+28.
